// File: rtl/xmem_mp_to_bram.sv
// Bridges NUM_PORTS narrow xmem ports onto one wide single-port BRAM with round-robin
// arbitration, one access per cycle and a fixed BRAM_READ_LATENCY response pipeline.
`timescale 1ns/1ps
module xmem_mp_to_bram #(
  parameter int NUM_PORTS         = 2,
  parameter int XADDR_WIDTH       = 32,
  parameter int XDATA_WIDTH       = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 128,
  parameter int BRAM_READ_LATENCY = 2,
  parameter int BRAM_DEPTH        = 1024
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [NUM_PORTS-1:0]               xmem_req,
  input  logic [NUM_PORTS*XADDR_WIDTH-1:0]   xmem_addr,
  input  logic [NUM_PORTS-1:0]               xmem_we,
  input  logic [NUM_PORTS*XDATA_WIDTH-1:0]   xmem_wdata,
  input  logic [NUM_PORTS*XDATA_WIDTH/8-1:0] xmem_be,
  output logic [NUM_PORTS-1:0]               xmem_gnt,
  output logic [NUM_PORTS-1:0]               xmem_rsp_valid,
  output logic [NUM_PORTS*XDATA_WIDTH-1:0]   xmem_rsp_rdata,
  output logic [NUM_PORTS-1:0]               xmem_rsp_error,
  output logic [ADDR_WIDTH-1:0]              bram_addra,
  output logic [DATA_WIDTH-1:0]              bram_dina,
  input  logic [DATA_WIDTH-1:0]              bram_douta,
  output logic                               bram_ena,
  output logic [DATA_WIDTH/8-1:0]            bram_wea
);
  localparam int XB    = XDATA_WIDTH / 8;
  localparam int LB    = DATA_WIDTH / 8;
  localparam int LANES = DATA_WIDTH / XDATA_WIDTH;
  localparam int OFF   = $clog2(LB);
  localparam int LOFF  = $clog2(XB);
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int L     = BRAM_READ_LATENCY;

  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]          sel;
  logic                   found, acc;
  logic [XADDR_WIDTH-1:0] sel_addr, line;
  logic [XDATA_WIDTH-1:0] sel_wdata;
  logic [XB-1:0]          sel_be;
  logic                   sel_we, in_range;
  logic [LW-1:0]          sel_lane;

  logic [L-1:0]  vld_q, vld_d;
  logic [PW-1:0] port_q [L];
  logic [PW-1:0] port_d [L];
  logic [LW-1:0] lane_q [L];
  logic [LW-1:0] lane_d [L];
  logic [L-1:0]  we_q, we_d;
  logic [L-1:0]  err_q, err_d;
  logic [XDATA_WIDTH-1:0] lane_data;

  // Two passes: first requester at/after the pointer, else wrap to the lowest requester.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && xmem_req[i] && (i >= int'(rr_ptr_q))) begin
        found = 1'b1;
        sel   = PW'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && xmem_req[i]) begin
        found = 1'b1;
        sel   = PW'(i);
      end
    end
    acc      = found && aresetn;
    xmem_gnt = '0;
    if (acc) xmem_gnt[sel] = 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (acc) rr_ptr_d = (int'(sel) == NUM_PORTS - 1) ? '0 : sel + PW'(1);
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (PW'(i) == sel) begin
        sel_addr  = xmem_addr[i*XADDR_WIDTH +: XADDR_WIDTH];
        sel_wdata = xmem_wdata[i*XDATA_WIDTH +: XDATA_WIDTH];
        sel_be    = xmem_be[i*XB +: XB];
        sel_we    = xmem_we[i];
      end
    end
    line     = sel_addr >> OFF;
    sel_lane = (LANES > 1) ? LW'(sel_addr >> LOFF) : '0;
    in_range = line < XADDR_WIDTH'(BRAM_DEPTH);
  end

  // Issue stage: BRAM access happens in the grant cycle.
  always_comb begin
    bram_ena   = acc && in_range;
    bram_addra = ADDR_WIDTH'(line);
    bram_dina  = {LANES{sel_wdata}};
    bram_wea   = '0;
    if (bram_ena && sel_we) bram_wea = LB'(sel_be) << (int'(sel_lane) * XB);
  end

  always_comb begin
    vld_d[0]  = acc;
    port_d[0] = sel;
    lane_d[0] = sel_lane;
    we_d[0]   = sel_we;
    err_d[0]  = !in_range;
    for (int k = 1; k < L; k++) begin
      vld_d[k]  = vld_q[k-1];
      port_d[k] = port_q[k-1];
      lane_d[k] = lane_q[k-1];
      we_d[k]   = we_q[k-1];
      err_d[k]  = err_q[k-1];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge aclk) begin
    port_q <= port_d;
    lane_q <= lane_d;
    we_q   <= we_d;
    err_q  <= err_d;
  end

  // Response stage: last pipeline entry lines up with BRAM output data.
  always_comb begin
    lane_data = '0;
    for (int j = 0; j < LANES; j++) begin
      if (LW'(j) == lane_q[L-1]) lane_data = bram_douta[j*XDATA_WIDTH +: XDATA_WIDTH];
    end
    xmem_rsp_valid = '0;
    xmem_rsp_error = '0;
    xmem_rsp_rdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (vld_q[L-1] && (port_q[L-1] == PW'(i))) begin
        xmem_rsp_valid[i] = 1'b1;
        xmem_rsp_error[i] = err_q[L-1];
        if (!we_q[L-1] && !err_q[L-1])
          xmem_rsp_rdata[i*XDATA_WIDTH +: XDATA_WIDTH] = lane_data;
      end
    end
  end

endmodule

// File: tb/tb_xmem_mp_to_bram.sv
// Scoreboard bench for xmem_mp_to_bram: per-port command driver, BRAM model, response monitor.
`timescale 1ns/1ps
module tb_xmem_mp_to_bram;
  localparam int NP = 2, XAW = 32, XDW = 32, AW = 32, DW = 128, LAT = 2, DEPTH = 1024;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [NP-1:0]       xmem_req, xmem_we, xmem_gnt, xmem_rsp_valid, xmem_rsp_error;
  logic [NP*XAW-1:0]   xmem_addr;
  logic [NP*XDW-1:0]   xmem_wdata, xmem_rsp_rdata;
  logic [NP*XDW/8-1:0] xmem_be;
  logic [AW-1:0]       bram_addra;
  logic [DW-1:0]       bram_dina, bram_douta;
  logic                bram_ena;
  logic [DW/8-1:0]     bram_wea;

  xmem_mp_to_bram #(
    .NUM_PORTS(NP), .XADDR_WIDTH(XAW), .XDATA_WIDTH(XDW), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .BRAM_READ_LATENCY(LAT), .BRAM_DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .xmem_req(xmem_req), .xmem_addr(xmem_addr), .xmem_we(xmem_we),
    .xmem_wdata(xmem_wdata), .xmem_be(xmem_be), .xmem_gnt(xmem_gnt),
    .xmem_rsp_valid(xmem_rsp_valid), .xmem_rsp_rdata(xmem_rsp_rdata),
    .xmem_rsp_error(xmem_rsp_error), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .bram_douta(bram_douta), .bram_ena(bram_ena), .bram_wea(bram_wea)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // BRAM model, read latency 2
  bit [DW-1:0] mem [0:DEPTH-1];
  bit [DW-1:0] rd_p0, rd_p1;
  always @(posedge aclk) begin
    if (bram_ena) begin
      for (int b = 0; b < DW/8; b++)
        if (bram_wea[b]) mem[bram_addra[9:0]][b*8 +: 8] <= bram_dina[b*8 +: 8];
      rd_p0 <= mem[bram_addra[9:0]];
    end
    rd_p1 <= rd_p0;
  end
  assign bram_douta = rd_p1;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [15:0] exp_wea;
    logic [31:0] exp_line;
  } cmd_t;

  typedef struct packed {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  cmd_t cmds [NP][64];
  int   n_cmd [NP];
  int   rd_idx [NP];
  exp_t sb [$];
  int   acc_log [64];
  int   acc_cyc [64];
  int   acc_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   t2_exp [6] = '{1, 0, 1, 0, 1, 0};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int p, input logic [31:0] addr, input logic we,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input logic [15:0] exp_wea, input logic [31:0] exp_line);
    cmds[p][n_cmd[p]] = '{addr, we, wdata, be, exp_rdata, exp_err, exp_wea, exp_line};
    n_cmd[p]++;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int k = 0; k < max_cyc && !done; k++) begin
      @(negedge aclk);
      if (rd_idx[0] == n_cmd[0] && rd_idx[1] == n_cmd[1] && sb.size() == 0) done = 1'b1;
    end
    if (!done) chk("idle_timeout", sb.size(), 0);
    repeat (3) @(negedge aclk);
  endtask

  // Driver: keeps each port's current command on the bus until granted.
  initial begin : driver
    logic [NP-1:0] acc;
    cmd_t c;
    xmem_req = '0; xmem_we = '0; xmem_addr = '0; xmem_wdata = '0; xmem_be = '0;
    forever begin
      @(negedge aclk);
      acc = xmem_req & xmem_gnt;
      if (!aresetn) begin
        sb.delete();
      end else begin
        if (acc == '0) begin
          chk("idle_ena", bram_ena, 0);
          chk("idle_wea", bram_wea, 0);
        end
        for (int p = 0; p < NP; p++) begin
          if (acc[p]) begin
            c = cmds[p][rd_idx[p]];
            chk("issue_ena", bram_ena, !c.exp_err);
            chk("issue_wea", bram_wea, c.exp_wea);
            if (!c.exp_err) chk("issue_addra", bram_addra, c.exp_line);
            if (c.we && !c.exp_err) chk("issue_dina", bram_dina, {4{c.wdata}});
            sb.push_back('{p, c.exp_rdata, c.exp_err, cyc});
            acc_log[acc_cnt] = p;
            acc_cyc[acc_cnt] = cyc;
            acc_cnt++;
          end
        end
      end
      @(posedge aclk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (acc[p]) rd_idx[p]++;
        if (rd_idx[p] < n_cmd[p]) begin
          c = cmds[p][rd_idx[p]];
          xmem_req[p] = 1'b1;
          xmem_we[p]  = c.we;
          xmem_addr[p*32 +: 32]  = c.addr;
          xmem_wdata[p*32 +: 32] = c.wdata;
          xmem_be[p*4 +: 4]      = c.be;
        end else begin
          xmem_req[p] = 1'b0;
          xmem_we[p]  = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the oldest expectation whenever a response appears.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge aclk);
      if (xmem_rsp_valid != '0) begin
        if ($countones(xmem_rsp_valid) != 1) chk("rsp_onehot", $countones(xmem_rsp_valid), 1);
        if (sb.size() == 0) begin
          chk("rsp_unexpected", xmem_rsp_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_port", xmem_rsp_valid, 1 << e.port);
          chk("rsp_latency", cyc - e.cyc, LAT);
          chk("rsp_rdata", xmem_rsp_rdata[e.port*32 +: 32], e.rdata);
          chk("rsp_error", xmem_rsp_error[e.port], e.err);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    bit seen;
    // reset state
    repeat (3) @(negedge aclk);
    chk("rst_gnt", xmem_gnt, 0);
    chk("rst_rsp_valid", xmem_rsp_valid, 0);
    chk("rst_rsp_error", xmem_rsp_error, 0);
    chk("rst_rsp_rdata", xmem_rsp_rdata, 0);
    chk("rst_ena", bram_ena, 0);
    @(posedge aclk); #2 aresetn = 1'b1;
    @(negedge aclk);

    // T1: four lanes of line 0, then read back
    push(0, 32'h0, 1, 32'h01234567, 4'hf, 32'h0, 0, 16'h000f, 0);
    push(0, 32'h4, 1, 32'h89abcdef, 4'hf, 32'h0, 0, 16'h00f0, 0);
    push(0, 32'h8, 1, 32'hfedcba98, 4'hf, 32'h0, 0, 16'h0f00, 0);
    push(0, 32'hc, 1, 32'h76543210, 4'hf, 32'h0, 0, 16'hf000, 0);
    push(0, 32'h0, 0, 32'h0, 4'h0, 32'h01234567, 0, 16'h0, 0);
    push(0, 32'h4, 0, 32'h0, 4'h0, 32'h89abcdef, 0, 16'h0, 0);
    push(0, 32'h8, 0, 32'h0, 4'h0, 32'hfedcba98, 0, 16'h0, 0);
    push(0, 32'hc, 0, 32'h0, 4'h0, 32'h76543210, 0, 16'h0, 0);
    wait_idle(100);

    // T2: both ports request continuously; pointer is 1 after T1
    base = acc_cnt;
    for (int k = 0; k < 3; k++) begin
      push(0, 32'h0, 0, 32'h0, 4'h0, 32'h01234567, 0, 16'h0, 0);
      push(1, 32'h4, 0, 32'h0, 4'h0, 32'h89abcdef, 0, 16'h0, 0);
    end
    wait_idle(100);
    for (int k = 0; k < 6; k++) chk("t2_order", acc_log[base + k], t2_exp[k]);
    chk("t2_b2b", acc_cyc[base + 5] - acc_cyc[base], 5);

    // T3: partial byte write into zeroed line 1
    push(0, 32'h14, 1, 32'haabbccdd, 4'b0101, 32'h0, 0, 16'h0050, 1);
    push(0, 32'h14, 0, 32'h0, 4'h0, 32'h00bb00dd, 0, 16'h0, 1);
    wait_idle(100);

    // T4: line 1024 is out of range
    push(1, 32'h4000, 0, 32'h0, 4'h0, 32'h0, 1, 16'h0, 32'h400);
    wait_idle(100);

    // T5: pointer is 0, write on port 0 then read on port 1 next cycle
    base = acc_cnt;
    push(0, 32'h20, 1, 32'hcafef00d, 4'hf, 32'h0, 0, 16'h000f, 2);
    push(1, 32'h20, 0, 32'h0, 4'h0, 32'hcafef00d, 0, 16'h0, 2);
    wait_idle(100);
    chk("t5_first", acc_log[base], 0);
    chk("t5_second", acc_log[base + 1], 1);
    chk("t5_b2b", acc_cyc[base + 1] - acc_cyc[base], 1);

    // be=0 write: enabled, no byte strobes, lane stays zero
    push(0, 32'h24, 1, 32'h12345678, 4'h0, 32'h0, 0, 16'h0, 2);
    push(0, 32'h24, 0, 32'h0, 4'h0, 32'h0, 0, 16'h0, 2);
    wait_idle(100);

    // T6: reset one cycle after a read grant on port 0 (pointer would be 1)
    base = acc_cnt;
    push(0, 32'h0, 0, 32'h0, 4'h0, 32'h01234567, 0, 16'h0, 0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge aclk); #2;
      if (acc_cnt > base) seen = 1'b1;
    end
    if (!seen) chk("t6_grant_timeout", acc_cnt, base + 1);
    aresetn = 1'b0;
    @(negedge aclk);
    push(0, 32'h4, 0, 32'h0, 4'h0, 32'h89abcdef, 0, 16'h0, 0);
    push(1, 32'h0, 0, 32'h0, 4'h0, 32'h01234567, 0, 16'h0, 0);
    repeat (2) @(negedge aclk);
    chk("t6_rst_gnt", xmem_gnt, 0);
    chk("t6_rst_rsp_valid", xmem_rsp_valid, 0);
    chk("t6_rst_ena", bram_ena, 0);
    @(posedge aclk); #2 aresetn = 1'b1;
    @(negedge aclk);
    chk("t6_ptr_reset", xmem_gnt, 2'b01);
    wait_idle(100);

    repeat (5) @(negedge aclk);
    chk("sb_empty_end", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
